// File: rtl/game_pkg.sv
// Shared types and default constants for the game status controller.
// Holds the FSM state encoding and saturating score helpers.
// No timing or flow control of its own.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PLAY   = 3'd1,
        ST_FREEZE = 3'd2,
        ST_WON    = 3'd3,
        ST_LOST   = 3'd4
    } game_state_t;

    localparam logic [6:0] START_TIME      = 7'd99;
    localparam logic [1:0] START_LIVES     = 2'd3;
    localparam logic [2:0] FREEZE_SECS     = 3'd5;
    localparam logic [9:0] MINE_PENALTY    = 10'd10;
    localparam logic [6:0] LOW_TIME_THRESH = 7'd10;
    localparam logic [9:0] SCORE_MAX       = 10'd1023;

    function automatic logic [9:0] score_add(input logic [9:0] a, input logic [6:0] b);
        logic [10:0] w_sum;
        w_sum = {1'b0, a} + {4'b0000, b};
        return w_sum[10] ? SCORE_MAX : w_sum[9:0];
    endfunction

    function automatic logic [9:0] score_sub(input logic [9:0] a, input logic [9:0] b);
        return (a > b) ? (a - b) : 10'd0;
    endfunction

endpackage

// File: rtl/sec_countdown.sv
// Loadable seconds down-counter: load wins over tick, floors at zero.
// Count and zero flag reflect a load/tick one cycle after it is applied.
// No backpressure; load/tick are sampled every cycle.
module sec_countdown #(
    parameter int           W       = 7,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_tick,
    output logic [W-1:0] o_count,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= RST_VAL;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_tick && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/game_status_ctrl.sv
// Round/lives/timer/score controller for the minesweeper-style game; scoring under GAME_STATUS_SCORE_EN.
// All outputs registered: effects appear the cycle after the input (edge) is sampled.
// No backpressure; every input is evaluated each cycle.
module game_status_ctrl #(
    parameter logic [6:0] START_TIME   = game_pkg::START_TIME,
    parameter logic [1:0] START_LIVES  = game_pkg::START_LIVES,
    parameter logic [2:0] FREEZE_SECS  = game_pkg::FREEZE_SECS,
    parameter logic [9:0] MINE_PENALTY = game_pkg::MINE_PENALTY
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_key,
    input  logic       one_sec,
    input  logic       mine_exploded,
    input  logic       game_won,
    input  logic       pause_time,
    output logic [2:0] game_state,
    output logic [1:0] lives,
    output logic [6:0] time_left,
    output logic [2:0] freeze_left,
    output logic [9:0] score,
    output logic       board_reset,
    output logic       play_en,
    output logic       low_time
);
    import game_pkg::*;

    game_state_t r_state, w_state_nxt;
    logic        r_start_q, r_won_q, r_pause_q;
    logic        w_start_rise, w_won_rise, w_pause_rise;
    logic        w_in_round, w_mine_final, w_win, w_timeout, w_frz_expire;
    logic        w_time_load, w_time_tick, w_time_zero;
    logic        w_frz_load, w_frz_tick, w_frz_zero;
    logic [2:0]  w_frz_load_val, w_frz;
    logic [6:0]  w_time, w_time_nxt;
    logic [1:0]  r_lives, w_lives_nxt;
    logic        r_board_reset, r_play_en, r_low_time;
    logic        w_board_reset_nxt, w_play_en_nxt, w_low_time_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_q <= 1'b0;
            r_won_q   <= 1'b0;
            r_pause_q <= 1'b0;
        end else begin
            r_start_q <= start_key;
            r_won_q   <= game_won;
            r_pause_q <= pause_time;
        end
    end

    assign w_start_rise = start_key  & ~r_start_q;
    assign w_won_rise   = game_won   & ~r_won_q;
    assign w_pause_rise = pause_time & ~r_pause_q;

    // Event priority: final-life hit > win > timeout > pause.
    assign w_in_round   = (r_state == ST_PLAY) || (r_state == ST_FREEZE);
    assign w_mine_final = w_in_round && mine_exploded && (r_lives <= 2'd1);
    assign w_win        = w_in_round && w_won_rise && !w_mine_final;
    assign w_timeout    = (r_state == ST_PLAY) && one_sec && (w_time_zero || (w_time == 7'd1))
                          && !w_mine_final && !w_won_rise;
    assign w_frz_expire = one_sec && (w_frz_zero || (w_frz == 3'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_rise) w_state_nxt = ST_PLAY;
            end
            ST_PLAY, ST_FREEZE: begin
                if (w_mine_final || w_timeout)                   w_state_nxt = ST_LOST;
                else if (w_win)                                  w_state_nxt = ST_WON;
                else if (w_pause_rise)                           w_state_nxt = ST_FREEZE;
                else if ((r_state == ST_FREEZE) && w_frz_expire) w_state_nxt = ST_PLAY;
            end
            ST_WON, ST_LOST: begin
                if (w_start_rise) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_time_load       = 1'b0;
        w_time_tick       = 1'b0;
        w_frz_load        = 1'b0;
        w_frz_load_val    = 3'd0;
        w_frz_tick        = 1'b0;
        w_lives_nxt       = r_lives;
        w_board_reset_nxt = 1'b0;
        if ((r_state == ST_IDLE) && w_start_rise) begin
            w_time_load       = 1'b1;
            w_frz_load        = 1'b1;
            w_lives_nxt       = START_LIVES;
            w_board_reset_nxt = 1'b1;
        end
        if (w_in_round) begin
            if (mine_exploded && (r_lives != 2'd0)) w_lives_nxt = r_lives - 2'd1;
            if (!w_mine_final && !w_win) begin
                if (r_state == ST_PLAY) w_time_tick = one_sec;
                if (w_pause_rise && !w_timeout) begin
                    w_frz_load     = 1'b1;
                    w_frz_load_val = FREEZE_SECS;
                end else if (r_state == ST_FREEZE) begin
                    w_frz_tick = one_sec;
                end
            end
        end
    end

    // Look-ahead of the timer so low_time lines up with time_left.
    assign w_time_nxt     = w_time_load ? START_TIME :
                            (w_time_tick && !w_time_zero) ? (w_time - 7'd1) : w_time;
    assign w_play_en_nxt  = (w_state_nxt == ST_PLAY) || (w_state_nxt == ST_FREEZE);
    assign w_low_time_nxt = w_play_en_nxt && (w_time_nxt <= LOW_TIME_THRESH);

    sec_countdown #(.W(7), .RST_VAL(START_TIME)) u_time_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_time_load),
        .i_load_val (START_TIME),
        .i_tick     (w_time_tick),
        .o_count    (w_time),
        .o_zero     (w_time_zero)
    );

    sec_countdown #(.W(3), .RST_VAL(3'd0)) u_freeze_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_frz_load),
        .i_load_val (w_frz_load_val),
        .i_tick     (w_frz_tick),
        .o_count    (w_frz),
        .o_zero     (w_frz_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lives       <= START_LIVES;
            r_board_reset <= 1'b0;
            r_play_en     <= 1'b0;
            r_low_time    <= 1'b0;
        end else begin
            r_lives       <= w_lives_nxt;
            r_board_reset <= w_board_reset_nxt;
            r_play_en     <= w_play_en_nxt;
            r_low_time    <= w_low_time_nxt;
        end
    end

`ifdef GAME_STATUS_SCORE_EN
    logic [9:0] r_score, w_score_nxt;

    always_comb begin
        w_score_nxt = r_score;
        if ((r_state == ST_IDLE) && w_start_rise) begin
            w_score_nxt = 10'd0;
        end else if (w_in_round) begin
            if (mine_exploded) w_score_nxt = score_sub(w_score_nxt, MINE_PENALTY);
            if (w_win)         w_score_nxt = score_add(w_score_nxt, w_time);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_score <= 10'd0;
        end else begin
            r_score <= w_score_nxt;
        end
    end

    assign score = r_score;
`else
    // Scoring compiled out; the penalty parameter is kept so instantiations stay uniform.
    assign score = MINE_PENALTY & 10'd0;
`endif

    assign game_state  = r_state;
    assign lives       = r_lives;
    assign time_left   = w_time;
    assign freeze_left = w_frz;
    assign board_reset = r_board_reset;
    assign play_en     = r_play_en;
    assign low_time    = r_low_time;

endmodule

// File: tb/tb_game_status_ctrl.sv
// Bench for game_status_ctrl: directed scenarios plus random play against a reference model.
module tb_game_status_ctrl;

    localparam int M_IDLE = 0, M_PLAY = 1, M_FREEZE = 2, M_WON = 3, M_LOST = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start_key = 1'b0, one_sec = 1'b0, mine_exploded = 1'b0;
    logic       game_won = 1'b0, pause_time = 1'b0;
    logic [2:0] game_state;
    logic [1:0] lives;
    logic [6:0] time_left;
    logic [2:0] freeze_left;
    logic [9:0] score;
    logic       board_reset, play_en, low_time;

    int n_checks = 0;
    int n_fail   = 0;

    int m_st, m_lives, m_time, m_frz, m_score, m_brst;
    bit m_psk, m_pwon, m_ppz;

    game_status_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_key     (start_key),
        .one_sec       (one_sec),
        .mine_exploded (mine_exploded),
        .game_won      (game_won),
        .pause_time    (pause_time),
        .game_state    (game_state),
        .lives         (lives),
        .time_left     (time_left),
        .freeze_left   (freeze_left),
        .score         (score),
        .board_reset   (board_reset),
        .play_en       (play_en),
        .low_time      (low_time)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_lives = 3; m_time = 99; m_frz = 0; m_score = 0; m_brst = 0;
        m_psk = 0; m_pwon = 0; m_ppz = 0;
    endtask

    // Game rules at the level of a whole clock tick.
    task automatic model_step(input bit sk, input bit sec, input bit mine, input bit won, input bit pz);
        bit rs, rw, rp;
        rs = sk && !m_psk; rw = won && !m_pwon; rp = pz && !m_ppz;
        m_brst = 0;
        if (m_st == M_IDLE) begin
            if (rs) begin
                m_st = M_PLAY; m_time = 99; m_lives = 3; m_score = 0; m_frz = 0; m_brst = 1;
            end
        end else if (m_st == M_WON || m_st == M_LOST) begin
            if (rs) m_st = M_IDLE;
        end else begin
            if (mine) begin
                m_lives = m_lives - 1;
`ifdef GAME_STATUS_SCORE_EN
                m_score = (m_score > 10) ? m_score - 10 : 0;
`endif
            end
            if (mine && m_lives == 0) begin
                m_st = M_LOST;
            end else if (rw) begin
`ifdef GAME_STATUS_SCORE_EN
                m_score = (m_score + m_time > 1023) ? 1023 : m_score + m_time;
`endif
                m_st = M_WON;
            end else if (m_st == M_PLAY) begin
                if (sec && m_time > 0) m_time = m_time - 1;
                if (sec && m_time == 0) m_st = M_LOST;
                else if (rp) begin m_st = M_FREEZE; m_frz = 5; end
            end else begin
                if (rp) m_frz = 5;
                else if (sec) begin
                    m_frz = m_frz - 1;
                    if (m_frz == 0) m_st = M_PLAY;
                end
            end
        end
        m_psk = sk; m_pwon = won; m_ppz = pz;
    endtask

    task automatic check_outputs();
        bit pe;
        pe = (m_st == M_PLAY) || (m_st == M_FREEZE);
        chk("state", int'(game_state), m_st);
        chk("lives", int'(lives), m_lives);
        chk("time_left", int'(time_left), m_time);
        chk("freeze_left", int'(freeze_left), m_frz);
        chk("score", int'(score), m_score);
        chk("board_reset", int'(board_reset), m_brst);
        chk("play_en", int'(play_en), int'(pe));
        chk("low_time", int'(low_time), int'(pe && m_time <= 10));
    endtask

    task automatic cyc(input bit sk, input bit sec, input bit mine, input bit won, input bit pz);
        start_key = sk; one_sec = sec; mine_exploded = mine; game_won = won; pause_time = pz;
        @(posedge clk);
        model_step(sk, sec, mine, won, pz);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic go_play_from_end();
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        bit l_sk, l_won, l_pz;
        #1 rst_n = 1'b0;
        #2;
        model_reset();
        check_outputs();
        chk("rst_state_idle", int'(game_state), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Start a round: one-cycle board_reset pulse, full timer and lives.
        cyc(1, 0, 0, 0, 0);
        chk("start_brst", int'(board_reset), 1);
        chk("start_state", int'(game_state), 1);
        chk("start_time", int'(time_left), 99);
        chk("start_lives", int'(lives), 3);
        cyc(0, 0, 0, 0, 0);
        chk("brst_one_cycle", int'(board_reset), 0);

        // Full timeout, then an extra tick must not wrap.
        repeat (98) cyc(0, 1, 0, 0, 0);
        chk("time_at_1", int'(time_left), 1);
        cyc(0, 1, 0, 0, 0);
        chk("timeout_state", int'(game_state), 4);
        chk("timeout_time", int'(time_left), 0);
        cyc(0, 1, 0, 0, 0);
        chk("no_wrap", int'(time_left), 0);

        // Freeze at 50 s: five ticks drain freeze_left only.
        go_play_from_end();
        repeat (49) cyc(0, 1, 0, 0, 0);
        chk("time_50", int'(time_left), 50);
        cyc(0, 0, 0, 0, 1);
        chk("freeze_state", int'(game_state), 2);
        chk("freeze_load", int'(freeze_left), 5);
        repeat (5) cyc(0, 1, 0, 0, 1);
        chk("freeze_time_held", int'(time_left), 50);
        chk("freeze_done", int'(freeze_left), 0);
        chk("freeze_back_play", int'(game_state), 1);
        cyc(0, 0, 0, 0, 0);

        // Three mine hits drain lives and lose the round.
        repeat (3) cyc(0, 0, 1, 0, 0);
        chk("mines_lives", int'(lives), 0);
        chk("mines_state", int'(game_state), 4);

        // Final-life hit and win edge in the same cycle: the loss wins.
        go_play_from_end();
        repeat (2) cyc(0, 0, 1, 0, 0);
        chk("lives_1", int'(lives), 1);
        cyc(0, 0, 1, 1, 0);
        chk("mine_beats_win_state", int'(game_state), 4);
        chk("mine_beats_win_score", int'(score), 0);
        cyc(0, 0, 0, 0, 0);

        // Win at 40 s, then start returns to IDLE.
        go_play_from_end();
        repeat (59) cyc(0, 1, 0, 0, 0);
        chk("time_40", int'(time_left), 40);
        cyc(0, 0, 0, 1, 0);
        chk("win_state", int'(game_state), 3);
`ifdef GAME_STATUS_SCORE_EN
        chk("win_score", int'(score), 40);
`else
        chk("win_score", int'(score), 0);
`endif
        cyc(1, 0, 0, 0, 0);
        chk("won_to_idle", int'(game_state), 0);
        cyc(0, 0, 0, 0, 0);

        // Random play with occasional mid-round resets.
        l_sk = 0; l_won = 0; l_pz = 0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 24) == 0) l_sk  = !l_sk;
            if ($urandom_range(0, 79) == 0) l_won = !l_won;
            if ($urandom_range(0, 29) == 0) l_pz  = !l_pz;
            cyc(l_sk, $urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0, l_won, l_pz);
            if ($urandom_range(0, 1499) == 0) begin
                rst_n = 1'b0;
                #2;
                model_reset();
                check_outputs();
                #1 rst_n = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_status_ctrl.md
GAME_STATUS_CTRL -- requirements
Module: game_status_ctrl

Interface
REQ-001 Parameter START_TIME, default 7'd99, round length in seconds.
REQ-002 Parameter START_LIVES, default 2'd3, lives at round start.
REQ-003 Parameter FREEZE_SECS, default 3'd5, timer-freeze length granted by a time booster.
REQ-004 Parameter MINE_PENALTY, default 10'd10, score points lost per mine hit.
REQ-005 Ports SHALL be, one per line:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_key  in  1  level, start/restart request
- one_sec  in  1  single-cycle tick, once per second
- mine_exploded  in  1  single-cycle pulse, player hit a mine
- game_won  in  1  level, player reached goal tile
- pause_time  in  1  level, booster collected
- game_state  out  3  current FSM state code
- lives  out  2  remaining lives
- time_left  out  7  remaining round seconds
- freeze_left  out  3  remaining freeze seconds
- score  out  10  current score
- board_reset  out  1  one-cycle active-high pulse, re-initialises the board
- play_en  out  1  high in PLAY or FREEZE
- low_time  out  1  high while time_left <= 10 in PLAY/FREEZE

Function
REQ-006 FSM states SHALL be IDLE=0, PLAY=1, FREEZE=2, WON=3, LOST=4.
REQ-007 start_key, game_won and pause_time SHALL be acted on only at their registered rising edges; mine_exploded SHALL count once per high cycle.
REQ-008 IDLE->PLAY on start_key edge; in that same transition, time_left=START_TIME, lives=START_LIVES, score=0, freeze_left=0, and board_reset SHALL pulse for exactly one cycle.
REQ-009 In PLAY, each one_sec SHALL decrement time_left by 1; time_left SHALL never wrap below 0.
REQ-010 PLAY->LOST when a one_sec arrives with time_left==1 (time_left becomes 0).
REQ-011 PLAY->FREEZE on pause_time edge, with freeze_left=FREEZE_SECS.
REQ-012 In FREEZE, one_sec SHALL decrement freeze_left, not time_left; FREEZE->PLAY on the tick that takes freeze_left to 0.
REQ-013 A pause_time edge while in FREEZE SHALL reload freeze_left=FREEZE_SECS.
REQ-014 In PLAY or FREEZE, mine_exploded SHALL decrement lives; a hit with lives==1 SHALL go to LOST with lives=0.
REQ-015 In PLAY or FREEZE, a game_won edge SHALL go to WON and add time_left to score.
REQ-016 Simultaneous events in one cycle SHALL resolve in priority order: mine hit, then win, then timeout, then pause; a final-life hit SHALL beat a win, and a win SHALL beat a timeout.
REQ-017 WON/LOST->IDLE on start_key edge; all counters SHALL hold in WON/LOST/IDLE.
REQ-018 Score SHALL saturate at 0 on subtract and at 1023 on add.
REQ-019 All outputs SHALL be registered; state and counter updates SHALL be visible 1 cycle after the triggering input edge is registered.
REQ-020 Inputs other than start_key SHALL be ignored in IDLE, WON and LOST.

Reset
REQ-021 On rst_n low, asynchronously: state=IDLE, lives=START_LIVES, time_left=START_TIME, freeze_left=0, score=0, board_reset=0, play_en=0, low_time=0, and all edge-detect registers cleared.
REQ-022 Reset mid-round SHALL abandon the round with no board_reset pulse; the next round begins from IDLE.

Configuration
REQ-023 With GAME_STATUS_SCORE_EN defined, the score logic of REQ-004, REQ-015 and REQ-018 SHALL be present and each mine hit SHALL also subtract MINE_PENALTY.
REQ-024 Without GAME_STATUS_SCORE_EN, score SHALL be constant 0 and no score registers SHALL be synthesised.

Structure
REQ-025 Package game_pkg SHALL hold the game_state_t enum, the state codes, and the default constants START_TIME, START_LIVES, FREEZE_SECS and MINE_PENALTY.
REQ-026 One sub-module, sec_countdown, SHALL be used: a loadable down-counter with decrement-on-tick, zero-floor and a zero flag, instantiated for time_left and for freeze_left.

Verification
REQ-027 Reset, then a start_key edge -> board_reset high for 1 cycle, state=PLAY, time_left=99, lives=3.
REQ-028 PLAY, 99 one_sec ticks -> time_left=0, state=LOST; a further tick leaves time_left=0.
REQ-029 PLAY at time_left=50, pause_time rises, then 5 ticks -> time_left stays 50, freeze_left 5->0, state=PLAY.
REQ-030 Three mine_exploded pulses -> lives 3,2,1,0 and state=LOST; with score enabled and start score 25, score=0 (saturated).
REQ-031 Same cycle: mine_exploded at lives=1 and game_won edge -> state=LOST, score unchanged by the win.
REQ-032 game_won edge at time_left=40 with score=0 -> state=WON, score=40 (0 if GAME_STATUS_SCORE_EN undefined); then start_key edge -> state=IDLE.
